// File: rtl/board_ctrl_if.sv
// Board sequencer bundle: game-screen controls and move
// requests in, board state and result out.
interface board_ctrl_if;
  logic         start_en;
  logic         choice_en;
  logic         first_player;
  logic         click;
  logic [3:0]   click_sq;
  logic         new_game;
  logic [8:0]   square_en;
  logic [107:0] square_color;
  logic         turn;
  logic         game_over;
  logic [1:0]   winner;

  modport master (
    output start_en, choice_en, first_player,
    output click, click_sq, new_game,
    input  square_en, square_color,
    input  turn, game_over, winner
  );

  modport slave (
    input  start_en, choice_en, first_player,
    input  click, click_sq, new_game,
    output square_en, square_color,
    output turn, game_over, winner
  );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe sequencer: move acceptance, click hold-off,
// win/draw detection and square enables/colours for the overlays.
module board_ctrl #(
  parameter int HOLDOFF_CYCLES = 6_500_000
) (
  input logic         pclk,
  input logic         rst,
  board_ctrl_if.slave bus
);

  localparam int CW =
    (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, PLAY, CHECK, OVER
  } state_t;

  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t        state, state_nx;
  logic [8:0]    occ, occ_nx;
  logic [8:0]    col, col_nx;
  logic          turn, turn_nx;
  logic          over, over_nx;
  logic [1:0]    win, win_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [15:0] hot;
  logic [8:0]  sel;
  logic        go;
  logic        accept;
  logic        line_win;
  logic        full;

  assign hot  = 16'd1 << bus.click_sq;
  assign sel  = hot[8:0];
  assign go   = bus.start_en && !bus.choice_en;
  assign full = &occ;

  assign accept = bus.click && !bus.choice_en
               && (bus.click_sq <= 4'd8)
               && ((occ & sel) == 9'd0)
               && (cnt == '0);

  // A line is won when all three squares are taken and
  // their colour bits are either all set or all clear.
  always_comb begin
    line_win = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if ((occ & LINES[k]) == LINES[k]
          && ((col & LINES[k]) == LINES[k]
              || (col & LINES[k]) == 9'd0))
        line_win = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (go) state_nx = PLAY;
      PLAY: begin
        if (!bus.start_en) state_nx = IDLE;
        else if (accept)   state_nx = CHECK;
      end
      CHECK: begin
        if (!bus.start_en)       state_nx = IDLE;
        else if (line_win || full) state_nx = OVER;
        else                     state_nx = PLAY;
      end
      OVER: begin
        if (!bus.start_en || bus.new_game)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    occ_nx  = occ;
    col_nx  = col;
    turn_nx = turn;
    over_nx = over;
    win_nx  = win;
    cnt_nx  = (cnt != '0) ? cnt - 1'b1 : '0;
    unique case (state)
      IDLE: begin
        occ_nx  = '0;
        col_nx  = '0;
        over_nx = 1'b0;
        win_nx  = 2'b00;
        turn_nx = 1'b0;
        if (go) begin
          turn_nx = bus.first_player;
          cnt_nx  = '0;
        end
      end
      PLAY: begin
        if (!bus.start_en) begin
          occ_nx  = '0;
          col_nx  = '0;
          turn_nx = 1'b0;
        end else if (accept) begin
          occ_nx = occ | sel;
          col_nx = turn ? (col | sel) : (col & ~sel);
          cnt_nx = HOLD_LD;
        end
      end
      CHECK: begin
        if (!bus.start_en) begin
          occ_nx  = '0;
          col_nx  = '0;
          turn_nx = 1'b0;
        end else if (line_win) begin
          win_nx  = {turn, ~turn};
          over_nx = 1'b1;
        end else if (full) begin
          win_nx  = 2'b00;
          over_nx = 1'b1;
        end else begin
          turn_nx = ~turn;
        end
      end
      OVER: begin
        if (!bus.start_en || bus.new_game) begin
          occ_nx  = '0;
          col_nx  = '0;
          over_nx = 1'b0;
          win_nx  = 2'b00;
          turn_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      occ  <= '0;
      col  <= '0;
      turn <= 1'b0;
      over <= 1'b0;
      win  <= 2'b00;
      cnt  <= '0;
    end else begin
      occ  <= occ_nx;
      col  <= col_nx;
      turn <= turn_nx;
      over <= over_nx;
      win  <= win_nx;
      cnt  <= cnt_nx;
    end
  end

  assign bus.square_en = occ;
  assign bus.turn      = turn;
  assign bus.game_over = over;
  assign bus.winner    = win;

  for (genvar i = 0; i < 9; i++) begin : g_col
    assign bus.square_color[12*i +: 12] = {11'd0, col[i]};
  end

endmodule
